uart_mem_loader: RTL and testbench

//  Sequences the 8N1 UART byte receiver into program/data memory at boot: packs received bytes

---
 rtl/uart_mem_loader_if.sv | 33 +++
 rtl/uart_mem_loader.sv | 166 ++++++++++++++++
 tb/tb_uart_mem_loader.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_if.sv
// Byte-stream in / memory-write out bundle for uart_mem_loader.
// Handshake: i_byte_valid is a one-cycle strobe with no back-pressure, so every strobe is consumed.
// o_mem_we is a one-cycle strobe, and the memory is assumed to take the write in that cycle.
// dbg_state mirrors the loader FSM for observation only.
interface uart_mem_loader_if #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 32
);
   logic              i_start;
   logic [7:0]        i_byte;
   logic              i_byte_valid;
   logic              i_clear_sign;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [WORD_W-1:0] o_mem_wdata;
   logic              o_busy;
   logic              o_load_done;
   logic [ADDR_W:0]   o_word_count;
   logic              o_overflow;
   logic [2:0]        dbg_state;

   modport slave (
      input  i_start, i_byte, i_byte_valid, i_clear_sign,
      output o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_load_done,
             o_word_count, o_overflow, dbg_state
   );

   modport master (
      output i_start, i_byte, i_byte_valid, i_clear_sign,
      input  o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_load_done,
             o_word_count, o_overflow, dbg_state
   );
endinterface

// File: rtl/uart_mem_loader.sv
// Boot loader: packs UART bytes big-endian into words and writes them to memory at
// incrementing addresses until the receiver idle time-out. Define LOADER_PAD_PARTIAL_EN to
// zero-pad and write a trailing partial word; otherwise a trailing partial word is discarded.
module uart_mem_loader #(
   parameter int BYTES_PER_WORD = 4,
   parameter int ADDR_W         = 8,
   parameter int BASE_ADDR      = 0,
   parameter int MAX_WORDS      = 256
) (
   input  logic              i_clk_uart,
   input  logic              i_rst_n,
   uart_mem_loader_if.slave  bus
);
   localparam int WORD_W = 8 * BYTES_PER_WORD;
   localparam int IDX_W  = 2;
   localparam int AW1    = ADDR_W + 1;

   localparam logic [AW1-1:0]    MAX_C    = AW1'(MAX_WORDS);
   localparam logic [AW1-1:0]    CNT_ONE  = AW1'(1);
   localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_FIRST = 3'd1,
      S_COLLECT    = 3'd2,
      S_WRITE      = 3'd3,
      S_DONE       = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] asm_q, asm_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [AW1-1:0]    count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              term_q, term_d;

   logic              take_byte;
   logic              full;
   logic [WORD_W-1:0] asm_with_byte;

   // The word being written in WRITE already counts against capacity.
   assign full = (state_q == S_WRITE) ? ((count_q + CNT_ONE) >= MAX_C) : (count_q >= MAX_C);

   always_comb begin : merge_byte
      asm_with_byte = (idx_q == '0) ? '0 : asm_q;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         if (idx_q == IDX_W'(k)) begin
            asm_with_byte[(BYTES_PER_WORD-1-k)*8 +: 8] = bus.i_byte;
         end
      end
   end

   always_ff @(posedge i_clk_uart or negedge i_rst_n) begin : state_reg
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         asm_q   <= '0;
         wdata_q <= '0;
         addr_q  <= BASE_C;
         count_q <= '0;
         ovf_q   <= 1'b0;
         term_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         term_q  <= term_d;
      end
   end

   always_comb begin : next_state
      state_d   = state_q;
      idx_d     = idx_q;
      asm_d     = asm_q;
      wdata_d   = wdata_q;
      addr_d    = addr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      term_d    = term_q;
      take_byte = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.i_start) begin
               state_d = S_WAIT_FIRST;
               idx_d   = '0;
               asm_d   = '0;
               addr_d  = BASE_C;
               count_d = '0;
               ovf_d   = 1'b0;
               term_d  = 1'b0;
            end
         end
         S_WAIT_FIRST: begin
            if (bus.i_byte_valid) begin
               state_d   = S_COLLECT;
               take_byte = 1'b1;
            end
         end
         S_COLLECT: begin
            if (bus.i_byte_valid) begin
               take_byte = 1'b1;
            end else if (bus.i_clear_sign) begin
`ifdef LOADER_PAD_PARTIAL_EN
               if (idx_q != '0) begin
                  state_d = S_WRITE;
                  term_d  = 1'b1;
                  wdata_d = asm_q;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
               idx_d = '0;
               asm_d = '0;
            end
         end
         S_WRITE: begin
            addr_d  = addr_q + ADDR_ONE;
            count_d = count_q + CNT_ONE;
            term_d  = 1'b0;
            state_d = term_q ? S_DONE : S_COLLECT;
            if (bus.i_byte_valid && !term_q) begin
               take_byte = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (take_byte) begin
         if (full) begin
            ovf_d = 1'b1;
         end else if (idx_q == LAST_IDX) begin
            wdata_d = asm_with_byte;
            asm_d   = '0;
            idx_d   = '0;
            state_d = S_WRITE;
         end else begin
            asm_d = asm_with_byte;
            idx_d = idx_q + IDX_ONE;
         end
      end
   end

   always_comb begin : outputs
      bus.o_mem_we     = (state_q == S_WRITE);
      bus.o_mem_addr   = (state_q == S_WRITE) ? addr_q : '0;
      bus.o_mem_wdata  = (state_q == S_WRITE) ? wdata_q : '0;
      bus.o_busy       = (state_q == S_WAIT_FIRST) || (state_q == S_COLLECT) ||
                         (state_q == S_WRITE);
      bus.o_load_done  = (state_q == S_DONE);
      bus.o_word_count = count_q;
      bus.o_overflow   = ovf_q;
      bus.dbg_state    = state_q;
   end
endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: two instances (default, and a 2-byte-word, 2-word, wrapping-base one)
// share one byte stream and are checked every cycle against a byte/word-level reference model.
module tb_uart_mem_loader;
`ifdef LOADER_PAD_PARTIAL_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       bv = 1'b0;
   logic [7:0] bdat = 8'h00;
   logic       clr = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_mem_loader_if #(.ADDR_W(8), .WORD_W(32)) bus_a ();
   uart_mem_loader_if #(.ADDR_W(8), .WORD_W(16)) bus_b ();

   assign bus_a.i_start      = start;
   assign bus_a.i_byte       = bdat;
   assign bus_a.i_byte_valid = bv;
   assign bus_a.i_clear_sign = clr;
   assign bus_b.i_start      = start;
   assign bus_b.i_byte       = bdat;
   assign bus_b.i_byte_valid = bv;
   assign bus_b.i_clear_sign = clr;

   uart_mem_loader #(.BYTES_PER_WORD(4), .ADDR_W(8), .BASE_ADDR(0), .MAX_WORDS(256)) dut_a (
      .i_clk_uart(clk), .i_rst_n(rst_n), .bus(bus_a));
   uart_mem_loader #(.BYTES_PER_WORD(2), .ADDR_W(8), .BASE_ADDR(255), .MAX_WORDS(2)) dut_b (
      .i_clk_uart(clk), .i_rst_n(rst_n), .bus(bus_b));

   // ---------------- reference model ----------------
   localparam int P_IDLE = 0, P_ARMED = 1, P_ACTIVE = 2, P_DONE = 3;

   function automatic int bpw_of(input int d);  return (d == 0) ? 4 : 2;     endfunction
   function automatic int maxw_of(input int d); return (d == 0) ? 256 : 2;   endfunction
   function automatic int base_of(input int d); return (d == 0) ? 0 : 255;   endfunction

   int          m_phase[2];
   int          m_cnt[2];
   bit          m_ovf[2];
   bit          m_wr[2];
   bit          m_term[2];
   int          m_addr[2];
   int unsigned m_data[2];
   int          m_pn[2];
   int unsigned m_pval[2];
   bit          n_wr[2];
   bit          n_term[2];
   int          n_addr[2];
   int unsigned n_data[2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = P_IDLE; m_cnt[d] = 0; m_ovf[d] = 0; m_wr[d] = 0; m_term[d] = 0;
         m_addr[d] = 0; m_data[d] = 0; m_pn[d] = 0; m_pval[d] = 0;
      end
   endtask

   task automatic model_accept(input int d, input logic [7:0] b);
      int committed;
      committed = m_cnt[d] + (m_wr[d] ? 1 : 0);
      if (committed >= maxw_of(d)) begin
         m_ovf[d] = 1'b1;
      end else begin
         m_pval[d] = (m_pval[d] << 8) | 32'(b);
         m_pn[d]++;
         if (m_pn[d] == bpw_of(d)) begin
            n_wr[d] = 1'b1; n_term[d] = 1'b0;
            n_addr[d] = (base_of(d) + committed) % 256;
            n_data[d] = m_pval[d];
            m_pn[d] = 0; m_pval[d] = 0;
         end
      end
   endtask

   task automatic model_step(input int d);
      n_wr[d] = 1'b0; n_term[d] = 1'b0; n_addr[d] = 0; n_data[d] = 0;
      case (m_phase[d])
         P_IDLE, P_DONE: begin
            if (start) begin
               m_phase[d] = P_ARMED; m_cnt[d] = 0; m_ovf[d] = 0; m_pn[d] = 0; m_pval[d] = 0;
            end
         end
         P_ARMED: begin
            if (bv) begin
               m_phase[d] = P_ACTIVE;
               model_accept(d, bdat);
            end
         end
         default: begin
            if (m_wr[d] && m_term[d]) begin
               m_phase[d] = P_DONE;
            end else if (bv) begin
               model_accept(d, bdat);
            end else if (clr && !m_wr[d]) begin
               if (PAD && m_pn[d] > 0) begin
                  n_wr[d] = 1'b1; n_term[d] = 1'b1;
                  n_addr[d] = (base_of(d) + m_cnt[d]) % 256;
                  n_data[d] = m_pval[d] << (8 * (bpw_of(d) - m_pn[d]));
               end else begin
                  m_phase[d] = P_DONE;
               end
               m_pn[d] = 0; m_pval[d] = 0;
            end
         end
      endcase
      if (m_wr[d]) m_cnt[d]++;
      m_wr[d] = n_wr[d]; m_term[d] = n_term[d]; m_addr[d] = n_addr[d]; m_data[d] = n_data[d];
   endtask

   initial model_reset();

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else begin
         model_step(0);
         model_step(1);
      end
   end

   // ---------------- scoreboard ----------------
   logic [7:0]  log_addr_a[$];
   logic [31:0] log_data_a[$];
   logic [7:0]  log_addr_b[$];
   logic [31:0] log_data_b[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input int d, input logic we, input logic [7:0] addr,
                          input logic [31:0] data, input logic busy, input logic done,
                          input logic [8:0] cnt, input logic ovf);
      string p;
      p = (d == 0) ? "a" : "b";
      chk({p, "_we"}, 32'(we), 32'(m_wr[d]));
      if (m_wr[d]) begin
         chk({p, "_addr"}, 32'(addr), 32'(m_addr[d]));
         chk({p, "_wdata"}, data, m_data[d]);
      end
      chk({p, "_busy"}, 32'(busy), 32'(m_phase[d] == P_ARMED || m_phase[d] == P_ACTIVE));
      chk({p, "_done"}, 32'(done), 32'(m_phase[d] == P_DONE));
      chk({p, "_count"}, 32'(cnt), 32'(m_cnt[d]));
      chk({p, "_overflow"}, 32'(ovf), 32'(m_ovf[d]));
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         cmp_dut(0, bus_a.o_mem_we, bus_a.o_mem_addr, bus_a.o_mem_wdata, bus_a.o_busy,
                 bus_a.o_load_done, bus_a.o_word_count, bus_a.o_overflow);
         cmp_dut(1, bus_b.o_mem_we, bus_b.o_mem_addr, 32'(bus_b.o_mem_wdata), bus_b.o_busy,
                 bus_b.o_load_done, bus_b.o_word_count, bus_b.o_overflow);
         if (bus_a.o_mem_we) begin
            log_addr_a.push_back(bus_a.o_mem_addr);
            log_data_a.push_back(bus_a.o_mem_wdata);
         end
         if (bus_b.o_mem_we) begin
            log_addr_b.push_back(bus_b.o_mem_addr);
            log_data_b.push_back(32'(bus_b.o_mem_wdata));
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic step(input logic s, input logic v, input logic [7:0] b, input logic c);
      start = s; bv = v; bdat = b; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      log_addr_a.delete(); log_data_a.delete(); log_addr_b.delete(); log_data_b.delete();
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_a_we"},    32'(bus_a.o_mem_we), 32'd0);
      chk({tag, "_a_addr"},  32'(bus_a.o_mem_addr), 32'd0);
      chk({tag, "_a_wdata"}, bus_a.o_mem_wdata, 32'd0);
      chk({tag, "_a_busy"},  32'(bus_a.o_busy), 32'd0);
      chk({tag, "_a_done"},  32'(bus_a.o_load_done), 32'd0);
      chk({tag, "_a_count"}, 32'(bus_a.o_word_count), 32'd0);
      chk({tag, "_a_ovf"},   32'(bus_a.o_overflow), 32'd0);
      chk({tag, "_b_busy"},  32'(bus_b.o_busy), 32'd0);
      chk({tag, "_b_count"}, 32'(bus_b.o_word_count), 32'd0);
   endtask

   logic [7:0] t1_bytes [8];

   initial begin
      int nb, gap, hold;
      logic last_clr;
      t1_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

      repeat (3) step(0, 0, 8'h00, 0);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      step(0, 0, 8'h00, 0);

      // T1 back-to-back bytes, fifth byte lands in the WRITE cycle
      clear_logs();
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 8; i++) step(0, 1, t1_bytes[i], 0);
      repeat (4) step(0, 0, 8'h00, 1);
      chk("t1_nwrites_a", 32'(log_addr_a.size()), 32'd2);
      if (log_addr_a.size() == 2) begin
         chk("t1_addr0_a", 32'(log_addr_a[0]), 32'd0);
         chk("t1_data0_a", log_data_a[0], 32'h12345678);
         chk("t1_addr1_a", 32'(log_addr_a[1]), 32'd1);
         chk("t1_data1_a", log_data_a[1], 32'h9ABCDEF0);
      end
      chk("t1_count_a", 32'(bus_a.o_word_count), 32'd2);
      chk("t1_done_a", 32'(bus_a.o_load_done), 32'd1);
      // T3 capacity on the 2-word instance, base 255 wraps to 0
      chk("t3_nwrites_b", 32'(log_addr_b.size()), 32'd2);
      if (log_addr_b.size() == 2) begin
         chk("t3_addr0_b", 32'(log_addr_b[0]), 32'd255);
         chk("t3_data0_b", log_data_b[0], 32'h1234);
         chk("t3_addr1_b", 32'(log_addr_b[1]), 32'd0);
         chk("t3_data1_b", log_data_b[1], 32'h5678);
      end
      chk("t3_overflow_b", 32'(bus_b.o_overflow), 32'd1);
      chk("t3_done_b", 32'(bus_b.o_load_done), 32'd1);

      // T2 trailing partial word
      clear_logs();
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'hAA, 0);
      step(0, 0, 8'h00, 0);
      step(0, 1, 8'hBB, 0);
      repeat (4) step(0, 0, 8'h00, 1);
      chk("t2_nwrites_a", 32'(log_addr_a.size()), PAD ? 32'd1 : 32'd0);
      if (log_data_a.size() > 0) chk("t2_data_a", log_data_a[0], 32'hAABB0000);
      chk("t2_count_a", 32'(bus_a.o_word_count), PAD ? 32'd1 : 32'd0);
      chk("t2_done_a", 32'(bus_a.o_load_done), 32'd1);
      chk("t2_overflow_a", 32'(bus_a.o_overflow), 32'd0);

      // T4 clear high before the first byte is ignored
      clear_logs();
      step(1, 0, 8'h00, 1);
      repeat (5) step(0, 0, 8'h00, 1);
      chk("t4_busy_a", 32'(bus_a.o_busy), 32'd1);
      chk("t4_done_a", 32'(bus_a.o_load_done), 32'd0);
      chk("t4_nwrites_a", 32'(log_addr_a.size()), 32'd0);

      // T6 last byte coincides with clear rise
      step(0, 1, 8'h01, 0);
      step(0, 1, 8'h02, 0);
      step(0, 1, 8'h03, 0);
      step(0, 1, 8'h04, 1);
      repeat (3) step(0, 0, 8'h00, 1);
      chk("t6_nwrites_a", 32'(log_addr_a.size()), 32'd1);
      if (log_data_a.size() > 0) chk("t6_data_a", log_data_a[0], 32'h01020304);
      chk("t6_done_a", 32'(bus_a.o_load_done), 32'd1);
      step(1, 0, 8'h00, 1);
      chk("t6_rearm_busy_a", 32'(bus_a.o_busy), 32'd1);
      chk("t6_rearm_count_a", 32'(bus_a.o_word_count), 32'd0);

      // T5 asynchronous reset after three bytes, then a fresh load from address 0
      clear_logs();
      step(0, 1, 8'h11, 0);
      step(0, 1, 8'h22, 0);
      step(0, 1, 8'h33, 0);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("t5_async");
      step(0, 1, 8'h44, 0);
      rst_n = 1'b1;
      step(0, 0, 8'h00, 0);
      chk("t5_nwrites_a", 32'(log_addr_a.size()), 32'd0);
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'h44, 0);
      step(0, 1, 8'h55, 0);
      step(0, 1, 8'h66, 0);
      step(0, 1, 8'h77, 0);
      repeat (3) step(0, 0, 8'h00, 1);
      chk("t5_nwrites_after_a", 32'(log_addr_a.size()), 32'd1);
      if (log_addr_a.size() > 0) begin
         chk("t5_addr_a", 32'(log_addr_a[0]), 32'd0);
         chk("t5_data_a", log_data_a[0], 32'h44556677);
      end

      // randomized loads, checked cycle by cycle against the model
      for (int n = 0; n < 60; n++) begin
         step(1, 0, 8'h00, 1'($urandom_range(0, 1)));
         hold = $urandom_range(0, 3);
         for (int k = 0; k < hold; k++) step(1'($urandom_range(0, 7) == 0), 0, 8'h00, 1);
         nb = $urandom_range(0, 11);
         for (int k = 0; k < nb; k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step(0, 0, 8'h00, 0);
            last_clr = (k == nb - 1) && ($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 7) == 0), 1, 8'($urandom), last_clr);
            if (k == 4 && $urandom_range(0, 9) == 0) begin
               rst_n = 1'b0;
               step(0, 0, 8'h00, 0);
               rst_n = 1'b1;
            end
         end
         hold = $urandom_range(2, 5);
         for (int k = 0; k < hold; k++) step(0, 0, 8'h00, 1);
         hold = $urandom_range(0, 2);
         for (int k = 0; k < hold; k++) step(0, 0, 8'h00, 0);
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
